// File: rtl/dpll_lock_controller.sv
// dpll_lock_controller
// Lock sequencing for an XOR phase detector DPLL. The detector output is
// synchronized, its high time is integrated over fixed 2^WIN_BITS-cycle
// windows, and each closed window yields a signed phase-error word
// (high count minus half the window). An IDLE/ACQUIRE/TRACK state machine
// gates the loop filter and reports lock from runs of in-tolerance windows.
//
// Handshake: measValid is a one-cycle strobe with no back-pressure; phaseErr
// is valid on the cycle measValid is high and holds until the next strobe.
//
// state_dbg encoding: 0 = IDLE, 1 = ACQUIRE, 2 = TRACK.
module dpll_lock_controller #(
    parameter int WIN_BITS    = 10,
    parameter int LOCK_TOL    = 16,
    parameter int LOCK_WINS   = 4,
    parameter int UNLOCK_WINS = 2
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       enable,
    input  logic                       errSig,
    output logic signed [WIN_BITS:0]   phaseErr,
    output logic                       measValid,
    output logic                       loopEn,
    output logic                       trackMode,
    output logic                       locked,
    output logic [1:0]                 state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } state_t;

    localparam int GOOD_W = (LOCK_WINS   < 1) ? 1 : $clog2(LOCK_WINS + 1);
    localparam int BAD_W  = (UNLOCK_WINS < 1) ? 1 : $clog2(UNLOCK_WINS + 1);

    localparam logic [WIN_BITS:0]        HALF     = (WIN_BITS + 1)'(2 ** (WIN_BITS - 1));
    localparam logic signed [WIN_BITS:0] TOL_POS  = (WIN_BITS + 1)'(LOCK_TOL);
    localparam logic signed [WIN_BITS:0] TOL_NEG  = -TOL_POS;
    localparam logic [GOOD_W-1:0]        GOOD_MAX = GOOD_W'(LOCK_WINS);
    localparam logic [BAD_W-1:0]         BAD_MAX  = BAD_W'(UNLOCK_WINS);

    state_t                     state;
    logic                       sync_meta;
    logic                       err_s;
    logic [WIN_BITS-1:0]        win_cnt;
    logic [WIN_BITS:0]          hi_cnt;
    logic [GOOD_W-1:0]          good_cnt;
    logic [BAD_W-1:0]           bad_cnt;

    logic                       win_last;
    logic [WIN_BITS:0]          hi_final;
    logic signed [WIN_BITS:0]   phase_new;
    logic                       in_lock;
    logic [GOOD_W-1:0]          good_next;
    logic [BAD_W-1:0]           bad_next;

    assign state_dbg = state;

    // Two-flop synchronizer for the asynchronous detector output.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_meta <= 1'b0;
            err_s     <= 1'b0;
        end else begin
            sync_meta <= errSig;
            err_s     <= sync_meta;
        end
    end

    // The wrap cycle's own sample belongs to the closing window, so the
    // final count includes err_s before being compared against half-window.
    assign win_last  = (win_cnt == {WIN_BITS{1'b1}});
    assign hi_final  = hi_cnt + {{WIN_BITS{1'b0}}, err_s};
    assign phase_new = $signed(hi_final - HALF);
    assign in_lock   = (phase_new >= TOL_NEG) && (phase_new <= TOL_POS);

    // Consecutive-window run counters as they would be after this close.
    always_comb begin
        good_next = good_cnt;
        bad_next  = bad_cnt;
        if (in_lock) begin
            good_next = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;
            bad_next  = '0;
        end else begin
            good_next = '0;
            bad_next  = (bad_cnt == BAD_MAX) ? bad_cnt : bad_cnt + 1'b1;
        end
    end

    // Lock state machine, window integration and registered outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= ST_IDLE;
            win_cnt   <= '0;
            hi_cnt    <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            phaseErr  <= '0;
            measValid <= 1'b0;
            loopEn    <= 1'b0;
            trackMode <= 1'b0;
            locked    <= 1'b0;
        end else if (!enable) begin
            // Dropping enable discards any partial window; phaseErr holds.
            state     <= ST_IDLE;
            win_cnt   <= '0;
            hi_cnt    <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            measValid <= 1'b0;
            loopEn    <= 1'b0;
            trackMode <= 1'b0;
            locked    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state     <= ST_ACQUIRE;
                    win_cnt   <= '0;
                    hi_cnt    <= '0;
                    good_cnt  <= '0;
                    bad_cnt   <= '0;
                    measValid <= 1'b0;
                    loopEn    <= 1'b1;
                    trackMode <= 1'b0;
                    locked    <= 1'b0;
                end
                ST_ACQUIRE, ST_TRACK: begin
                    win_cnt   <= win_cnt + 1'b1;
                    measValid <= win_last;
                    loopEn    <= 1'b1;
                    if (win_last) begin
                        hi_cnt   <= '0;
                        phaseErr <= phase_new;
                        good_cnt <= good_next;
                        bad_cnt  <= bad_next;
                        if (state == ST_ACQUIRE && good_next == GOOD_MAX) begin
                            state     <= ST_TRACK;
                            bad_cnt   <= '0;
                            trackMode <= 1'b1;
                            locked    <= 1'b1;
                        end else if (state == ST_TRACK && bad_next == BAD_MAX) begin
                            state     <= ST_ACQUIRE;
                            good_cnt  <= '0;
                            trackMode <= 1'b0;
                            locked    <= 1'b0;
                        end
                    end else begin
                        hi_cnt <= hi_final;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    measValid <= 1'b0;
                    loopEn    <= 1'b0;
                    trackMode <= 1'b0;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpll_lock_controller.sv
// Directed bench for dpll_lock_controller with a 64-cycle window.
// errSig is driven as a per-window stream whose element j lands in window
// sample j (the stream starts one cycle before enable rises, absorbing the
// synchronizer delay). Each window pushes its hand-computed {locked, phase}
// into exp_q; a negedge monitor pops it on every measValid pulse and checks
// the pulse spacing.
module tb_dpll_lock_controller;

    logic              clk = 1'b0;
    logic              rstN;
    logic              enable;
    logic              errSig;
    logic signed [6:0] phaseErr;
    logic              measValid;
    logic              loopEn;
    logic              trackMode;
    logic              locked;
    logic [1:0]        state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];

    int         cyc = 0;
    int         entry_cyc = 0;
    int         last_pulse = 0;
    bit         first_pending = 1'b0;
    logic [1:0] prev_state = 2'd0;

    dpll_lock_controller #(
        .WIN_BITS    (6),
        .LOCK_TOL    (2),
        .LOCK_WINS   (3),
        .UNLOCK_WINS (2)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .enable    (enable),
        .errSig    (errSig),
        .phaseErr  (phaseErr),
        .measValid (measValid),
        .loopEn    (loopEn),
        .trackMode (trackMode),
        .locked    (locked),
        .state_dbg (state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every measValid must match the oldest expected window.
    always @(negedge clk) begin
        logic [7:0]        e;
        logic signed [6:0] ep;
        if (state_dbg == 2'd1 && prev_state == 2'd0) begin
            entry_cyc     = cyc;
            first_pending = 1'b1;
        end
        prev_state = state_dbg;
        if (measValid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_meas_valid", int'(measValid), 0);
            end else begin
                e  = exp_q.pop_front();
                ep = e[6:0];
                check_eq("phase_err", int'(phaseErr), int'(ep));
                check_eq("locked", int'(locked), int'(e[7]));
                check_eq("track_mode", int'(trackMode), int'(e[7]));
                check_eq("loop_en_at_meas", int'(loopEn), 1);
                if (first_pending)
                    check_eq("first_meas_latency", cyc - entry_cyc, 64);
                else
                    check_eq("meas_cadence", cyc - last_pulse, 64);
            end
            last_pulse    = cyc;
            first_pending = 1'b0;
        end
    end

    // One 64-sample window; 'start' raises enable on stream element 1.
    task automatic drive_win(input int highs, input bit square, input bit start,
                             input bit exp_locked);
        exp_q.push_back({exp_locked, 7'(highs - 32)});
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            if (start && j == 1) begin
                check_eq("loop_en_before_enable", int'(loopEn), 0);
                enable = 1'b1;
            end
            if (start && j == 2)
                check_eq("loop_en_rise", int'(loopEn), 1);
            errSig = square ? ((j % 8) < 4) : (j < highs);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input int exp_phase);
        check_eq({tag, "_phase"}, int'(phaseErr), exp_phase);
        check_eq({tag, "_meas"}, int'(measValid), 0);
        check_eq({tag, "_loop_en"}, int'(loopEn), 0);
        check_eq({tag, "_track"}, int'(trackMode), 0);
        check_eq({tag, "_locked"}, int'(locked), 0);
        check_eq({tag, "_state"}, int'(state_dbg), 0);
    endtask

    initial begin
        rstN   = 1'b0;
        enable = 1'b0;
        errSig = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 0);
        rstN = 1'b1;

        // Idle with a toggling detector output: nothing may move.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            errSig = ~errSig;
            if (i % 50 == 49) check_idle_outputs("idle", 0);
        end

        // Acquisition at 50% duty: lock on the third window.
        drive_win(32, 1'b1, 1'b1, 1'b0);
        drive_win(32, 1'b1, 1'b0, 1'b0);
        drive_win(32, 1'b1, 1'b0, 1'b1);
        // Loss of lock: +5, 0, +5, +5 -> drops on the last one only.
        drive_win(37, 1'b0, 1'b0, 1'b1);
        drive_win(32, 1'b0, 1'b0, 1'b1);
        drive_win(37, 1'b0, 1'b0, 1'b1);
        drive_win(37, 1'b0, 1'b0, 1'b0);
        // Duty extremes.
        drive_win(64, 1'b0, 1'b0, 1'b0);
        drive_win(0,  1'b0, 1'b0, 1'b0);
        // Tolerance edge: +2 good, +3 breaks the run, then -2/+2/+2 lock.
        drive_win(34, 1'b0, 1'b0, 1'b0);
        drive_win(34, 1'b0, 1'b0, 1'b0);
        drive_win(35, 1'b0, 1'b0, 1'b0);
        drive_win(30, 1'b0, 1'b0, 1'b0);
        drive_win(34, 1'b0, 1'b0, 1'b0);
        drive_win(34, 1'b0, 1'b0, 1'b1);

        // Enable drop at cycle 30 of a window while in TRACK.
        for (int j = 0; j <= 30; j++) begin
            @(negedge clk);
            errSig = ((j % 8) < 4);
            if (j == 30) begin
                check_eq("loop_en_before_drop", int'(loopEn), 1);
                check_eq("locked_before_drop", int'(locked), 1);
                enable = 1'b0;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            errSig = ~errSig;
            if (i == 0 || i == 9) check_idle_outputs("dropped", 2);
        end

        // Re-enable: fresh window, first pulse 64 cycles after entry.
        drive_win(32, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            errSig = 1'b0;
        end

        // Asynchronous reset while running.
        check_eq("loop_en_running", int'(loopEn), 1);
        #2 rstN = 1'b0;
        #1;
        check_eq("async_rst_loop_en", int'(loopEn), 0);
        check_eq("async_rst_state", int'(state_dbg), 0);
        check_eq("async_rst_phase", int'(phaseErr), 0);

        check_eq("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
